// File: rtl/clk_freq_meter_pkg.sv
// clk_freq_meter_pkg: shared FSM encoding, channel count and default gate length for the frequency meter.
package clk_freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int NUM_CH = 4;
    localparam logic [31:0] DEF_GATE_CYCLES = 32'd50_000_000;

endpackage

// File: rtl/freq_meter_ch.sv
// freq_meter_ch: one channel - synchronizer, rising-edge detect, saturating edge counter with sticky overflow.
module freq_meter_ch #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  logic             clr,
    input  logic             load1,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   rise;

    assign rise = sync[SYNC_STAGES-1] & ~prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= '0;
            prev  <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig};
            prev <= sync[SYNC_STAGES-1];
            if (clr) begin
                count <= '0;
                ovf   <= 1'b0;
            end else if (load1) begin
                // an edge seen while results are latched opens the next window
                count <= CNT_W'(rise);
                ovf   <= 1'b0;
            end else if (rise) begin
                if (&count) ovf <= 1'b1;
                else count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: four-channel edge counter over a fixed clk gate window, with latched results and a read mux.
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter logic [31:0] GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       sig_in,
    input  logic [1:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_ovf,
    output logic             meas_valid,
    output logic             busy
);

    state_t             state, next;
    logic [31:0]        gate_cnt;
    logic [CNT_W-1:0]   cnt [NUM_CH];
    logic [CNT_W-1:0]   res [NUM_CH];
    logic [NUM_CH-1:0]  ovf, ovf_res;
    logic               clr, load1, last;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        freq_meter_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .sig   (sig_in[i]),
            .clr   (clr),
            .load1 (load1),
            .count (cnt[i]),
            .ovf   (ovf[i])
        );
    end

    always_comb begin
        next  = state;
        clr   = 1'b0;
        load1 = 1'b0;
        last  = gate_cnt == GATE_CYCLES - 32'd1;
        case (state)
            IDLE: begin
                clr = 1'b1;
                if (en) next = GATE;
            end
            GATE: begin
                if (!en) begin
                    next = IDLE;
                    clr  = 1'b1;
                end else if (last) begin
                    next = LATCH;
                end
            end
            LATCH: begin
                load1 = 1'b1;
                next  = en ? GATE : IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            meas_valid <= 1'b0;
            ovf_res    <= '0;
            for (int i = 0; i < NUM_CH; i++) res[i] <= '0;
        end else begin
            state      <= next;
            gate_cnt   <= (state == GATE && next == GATE) ? gate_cnt + 32'd1 : '0;
            meas_valid <= state == LATCH;
            if (load1) begin
                ovf_res <= ovf;
                for (int i = 0; i < NUM_CH; i++) res[i] <= cnt[i];
            end
        end
    end

    assign busy    = state != IDLE;
    assign rd_data = res[rd_sel];
    assign rd_ovf  = ovf_res[rd_sel];

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter: drives periodic/random square waves into a 32-bit and a 4-bit meter and checks
// every latched window against edge counts derived from the recorded input history.
module tb_clk_freq_meter;

    localparam int GC = 100;
    localparam int S  = 2;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [3:0]  sig_in = 4'b0;
    logic [1:0]  rd_sel = 2'd0;
    logic [31:0] rd_data;
    logic        rd_ovf, meas_valid, busy;
    logic [3:0]  rd_data4;
    logic        rd_ovf4, meas_valid4, busy4;

    int          n_assert = 0, n_fail = 0;
    int          cyc = 0, g = 0, w = 0;
    int          per[4] = '{4, 6, 8, 10};
    int          k[4] = '{0, 0, 0, 0};
    int          cur[4] = '{0, 0, 0, 0};
    int          exp_n[4] = '{0, 0, 0, 0};
    logic [3:0]  samp [65536];

    always #5 clk = ~clk;

    clk_freq_meter #(.GATE_CYCLES(GC), .CNT_W(32), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_ovf(rd_ovf), .meas_valid(meas_valid), .busy(busy)
    );

    clk_freq_meter #(.GATE_CYCLES(GC), .CNT_W(4), .SYNC_STAGES(S)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .rd_sel(rd_sel),
        .rd_data(rd_data4), .rd_ovf(rd_ovf4), .meas_valid(meas_valid4), .busy(busy4)
    );

    // Square-wave generator; a new period only takes effect at a wrap so high/low stay >= 2 cycles.
    initial forever begin
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            if (k[c] == 0) cur[c] = per[c];
            sig_in[c] = cur[c] != 0 && k[c] < cur[c] / 2;
            k[c] = cur[c] == 0 ? 0 : (k[c] + 1) % cur[c];
        end
    end

    // Input history as seen at each clk edge; a reset edge clears the synchronizer, i.e. looks like 0.
    initial forever begin
        @(posedge clk);
        cyc++;
        samp[cyc] = rst_n ? sig_in : 4'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Rises sampled at edge j are counted at edge j+S; count those landing in [lo, hi].
    function automatic int rises(input int c, input int lo, input int hi);
        int n = 0;
        for (int j = (lo - S > 1 ? lo - S : 1); j <= hi - S; j++)
            if (samp[j][c] && !samp[j-1][c]) n++;
        return n;
    endfunction

    task automatic run_window();
        bit seen = 0;
        int lo, hi, n;
        for (int t = 0; t < 2 * (GC + 1) && !seen; t++) begin
            @(negedge clk);
            seen = meas_valid;
        end
        check("meas_valid seen", 32'(seen), 1);
        check("meas_valid time", cyc, g + (w + 1) * (GC + 1));
        check("meas_valid cnt4", 32'(meas_valid4), 1);
        lo = w == 0 ? g + 1 : g + w * (GC + 1);
        hi = g + (w + 1) * (GC + 1) - 1;
        for (int c = 0; c < 4; c++) begin
            n = rises(c, lo, hi);
            exp_n[c] = n;
            rd_sel = 2'(c);
            #1;
            check($sformatf("rd_data w%0d ch%0d", w, c), rd_data, n);
            check($sformatf("rd_ovf w%0d ch%0d", w, c), 32'(rd_ovf), 0);
            check($sformatf("rd_data4 w%0d ch%0d", w, c), 32'(rd_data4), n > 15 ? 15 : n);
            check($sformatf("rd_ovf4 w%0d ch%0d", w, c), 32'(rd_ovf4), n > 15 ? 1 : 0);
        end
        w++;
        @(negedge clk);
        check("meas_valid one cycle", 32'(meas_valid), 0);
        check("busy running", 32'(busy), 1);
    endtask

    initial begin
        int mv;
        repeat (3) @(negedge clk);
        check("reset meas_valid", 32'(meas_valid), 0);
        check("reset busy", 32'(busy), 0);
        check("reset busy4", 32'(busy4), 0);
        for (int c = 0; c < 4; c++) begin
            rd_sel = 2'(c);
            #1;
            check($sformatf("reset rd_data ch%0d", c), rd_data, 0);
            check($sformatf("reset rd_ovf ch%0d", c), 32'(rd_ovf), 0);
        end
        rst_n = 1'b1;
        per = '{10, 0, 0, 0};
        repeat (30) @(negedge clk);
        // single channel, then continuous running through several stimulus changes
        en = 1'b1;
        g = cyc + 1;
        w = 0;
        repeat (2) run_window();
        per = '{4, 10, 20, 0};
        repeat (3) run_window();
        per = '{0, 0, 4, 0};
        repeat (2) run_window();
        per = '{0, 0, 0, 0};
        repeat (2) run_window();
        repeat (6) begin
            for (int c = 0; c < 4; c++)
                per[c] = $urandom_range(0, 5) == 0 ? 0 : 2 * int'($urandom_range(2, 12));
            repeat (2) run_window();
        end
        // abort mid-window
        repeat (50) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy), 0);
        check("abort busy4", 32'(busy4), 0);
        mv = 0;
        repeat (250) begin
            @(negedge clk);
            mv += int'(meas_valid);
        end
        check("abort no meas_valid", mv, 0);
        for (int c = 0; c < 4; c++) begin
            rd_sel = 2'(c);
            #1;
            check($sformatf("abort hold ch%0d", c), rd_data, exp_n[c]);
        end
        en = 1'b1;
        g = cyc + 1;
        w = 0;
        repeat (2) run_window();
        // reset mid-window
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset busy", 32'(busy), 0);
        for (int c = 0; c < 4; c++) begin
            rd_sel = 2'(c);
            #1;
            check($sformatf("midreset rd_data ch%0d", c), rd_data, 0);
        end
        mv = 0;
        repeat (150) begin
            @(negedge clk);
            mv += int'(meas_valid);
        end
        check("midreset no meas_valid", mv, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
